// File: rtl/ulpi_reg_access.sv
// ULPI link-side register access engine.
// Immediate/extended reads and writes with NXT throttling, abort retry and timeouts.
module ulpi_reg_access #(
  parameter bit EXT_ADDR_EN = 1'b1,
  parameter int TIMEOUT     = 1024,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_error,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  input  logic [7:0] ulpi_data_in,
  output logic [7:0] ulpi_data_out,
  output logic       ulpi_data_oe,
  output logic       ulpi_stp,
  output logic       busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_IDLE,
    S_TXCMD,
    S_EXTADDR,
    S_WDATA,
    S_STP,
    S_RD_TURN,
    S_RD_DATA,
    S_RD_END,
    S_ABORT,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic          wr_q;
  logic [7:0]    addr_q;
  logic [7:0]    wdata_q;
  logic          ext_q;
  logic          err_q, err_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [RW-1:0] retry_q, retry_d;

  logic          accept;
  logic          req_ext;
  logic          cur_wr;
  logic          cur_ext;
  logic [7:0]    cur_addr;
  logic [7:0]    data_d;
  logic          drive;
  logic          timed_out;
  logic          rd_capture;

  assign req_ext = (req_addr[7:6] != 2'b00) || (req_addr[5:0] == 6'h2F);
  assign accept  = (state_q == S_IDLE) && req_valid && !ulpi_dir;
  assign req_ready = accept;

  assign cur_wr   = accept ? req_write : wr_q;
  assign cur_ext  = accept ? req_ext   : ext_q;
  assign cur_addr = accept ? req_addr  : addr_q;

  assign timed_out  = (wait_q == TO_LAST);
  assign rd_capture = (state_q == S_RD_DATA) && ulpi_dir && !ulpi_nxt;

  assign drive = (state_q == S_TXCMD) || (state_q == S_EXTADDR) ||
                 (state_q == S_WDATA) || (state_q == S_STP);

  // Bus released combinationally the cycle DIR rises
  assign ulpi_data_oe = drive && !ulpi_dir;

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    retry_d = retry_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          retry_d = '0;
          if (req_ext && !EXT_ADDR_EN) begin
            state_d = S_RESP;
            err_d   = 1'b1;
          end else begin
            state_d = S_TXCMD;
            err_d   = 1'b0;
          end
        end
      end
      S_TXCMD, S_EXTADDR, S_WDATA: begin
        // DIR wins over NXT: PHY took the bus
        if (ulpi_dir) begin
          if (retry_q >= RMAX) begin
            state_d = S_RESP;
            err_d   = 1'b1;
          end else begin
            state_d = S_ABORT;
            retry_d = retry_q + RW'(1);
          end
        end else if (ulpi_nxt) begin
          if (state_q == S_WDATA) begin
            state_d = S_STP;
          end else if (state_q == S_TXCMD && ext_q) begin
            state_d = S_EXTADDR;
          end else if (wr_q) begin
            state_d = S_WDATA;
          end else begin
            state_d = S_RD_TURN;
          end
        end else if (timed_out) begin
          state_d = S_STP;
          err_d   = 1'b1;
        end
      end
      S_STP: begin
        state_d = S_RESP;
      end
      S_RD_TURN: begin
        if (ulpi_dir) begin
          state_d = S_RD_DATA;
        end else if (timed_out) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end
      end
      S_RD_DATA: begin
        if (rd_capture) begin
          state_d = S_RD_END;
        end else if (timed_out) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end
      end
      S_RD_END: begin
        if (!ulpi_dir) begin
          state_d = S_RESP;
        end else if (timed_out) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end
      end
      S_ABORT: begin
        if (!ulpi_dir) begin
          state_d = S_TXCMD;
        end else if (timed_out) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wait_d = wait_q + CW'(1);
    if (state_q == S_IDLE || state_d != state_q) begin
      wait_d = '0;
    end
  end

  // Bus byte is registered from the state being entered
  always_comb begin
    data_d = 8'h00;
    unique case (state_d)
      S_TXCMD:   data_d = {cur_wr ? 2'b10 : 2'b11,
                           cur_ext ? 6'h2F : cur_addr[5:0]};
      S_EXTADDR: data_d = addr_q;
      S_WDATA:   data_d = wdata_q;
      default:   data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      err_q         <= 1'b0;
      wait_q        <= '0;
      retry_q       <= '0;
      wr_q          <= 1'b0;
      addr_q        <= 8'h00;
      wdata_q       <= 8'h00;
      ext_q         <= 1'b0;
      ulpi_data_out <= 8'h00;
      ulpi_stp      <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_error     <= 1'b0;
      rsp_rdata     <= 8'h00;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      err_q         <= err_d;
      wait_q        <= wait_d;
      retry_q       <= retry_d;
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        ext_q   <= req_ext;
      end
      ulpi_data_out <= data_d;
      ulpi_stp      <= (state_d == S_STP);
      rsp_valid     <= (state_d == S_RESP);
      rsp_error     <= (state_d == S_RESP) && err_d;
      busy          <= (state_d != S_IDLE);
      if (rd_capture) begin
        rsp_rdata <= ulpi_data_in;
      end
    end
  end

endmodule

// File: tb/tb_ulpi_reg_access.sv
// Bench for ulpi_reg_access: table of register transfers plus
// hand-built abort, timeout, illegal-address and reset sequences.
module tb_ulpi_reg_access;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_valid2;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       ulpi_dir;
  logic       ulpi_nxt;
  logic [7:0] ulpi_data_in;

  logic       req_ready, rsp_valid, rsp_error, ulpi_data_oe, ulpi_stp, busy;
  logic [7:0] rsp_rdata, ulpi_data_out;
  logic       req_ready2, rsp_valid2, rsp_error2, oe2, stp2, busy2;
  logic [7:0] rsp_rdata2, data_out2;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] last_rd = 8'h00;

  always #5 clk = ~clk;

  ulpi_reg_access #(
    .EXT_ADDR_EN(1'b1), .TIMEOUT(16), .MAX_RETRY(3)
  ) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt), .ulpi_data_in(ulpi_data_in),
    .ulpi_data_out(ulpi_data_out), .ulpi_data_oe(ulpi_data_oe),
    .ulpi_stp(ulpi_stp), .busy(busy)
  );

  ulpi_reg_access #(
    .EXT_ADDR_EN(1'b0), .TIMEOUT(16), .MAX_RETRY(3)
  ) u_dut_noext (
    .clk(clk), .reset(reset),
    .req_valid(req_valid2), .req_ready(req_ready2),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_error(rsp_error2),
    .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt), .ulpi_data_in(ulpi_data_in),
    .ulpi_data_out(data_out2), .ulpi_data_oe(oe2),
    .ulpi_stp(stp2), .busy(busy2)
  );

  typedef struct {
    logic       wr;
    logic       ext;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         nxt_wait;
    logic [7:0] rdata;
    logic [7:0] exp_cmd;
    logic       exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one request at a negedge; returns at the negedge after acceptance
  task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    #1;
    chk("req_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = ~a;
    req_wdata = ~d;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [7:0] log_q[$];
    logic [7:0] exp_q[$];
    int stp_n = 0;
    int cmd_n = 0;
    int ph = 0;
    int rstep = 0;
    bit got = 0;
    bit ok;
    for (int i = 0; i <= v.nxt_wait; i++) exp_q.push_back(v.exp_cmd);
    if (v.ext) exp_q.push_back(v.addr);
    if (v.wr) begin
      exp_q.push_back(v.wdata);
      exp_q.push_back(8'h00);
    end
    issue(v.wr, v.addr, v.wdata);
    for (int c = 0; c < 40 && !got; c++) begin
      if (rsp_valid) begin
        got = 1;
      end else begin
        if (ulpi_data_oe) log_q.push_back(ulpi_data_out);
        if (ulpi_stp) stp_n++;
        if (ph == 1 && !ulpi_data_oe) ph = 2;
        if (ph == 2) begin
          case (rstep)
            0: begin
              chk($sformatf("oe_low_before_dir v%0d", idx), ulpi_data_oe, 0);
              ulpi_nxt = 1'b0;
              ulpi_dir = 1'b1;
              ulpi_data_in = 8'hEE;
            end
            1: begin
              ulpi_dir = 1'b1;
              ulpi_nxt = 1'b0;
              ulpi_data_in = v.rdata;
            end
            default: begin
              ulpi_dir = 1'b0;
              ulpi_data_in = 8'h00;
            end
          endcase
          rstep++;
        end else if (ph == 1) begin
          ulpi_nxt = !ulpi_stp;
        end else if (ph == 0 && ulpi_data_oe) begin
          cmd_n++;
          if (cmd_n == v.nxt_wait + 1) begin
            ulpi_nxt = 1'b1;
            ph = (v.wr || v.ext) ? 1 : 2;
          end else begin
            ulpi_nxt = 1'b0;
          end
        end
        @(negedge clk);
      end
    end
    ulpi_nxt = 1'b0;
    ulpi_dir = 1'b0;
    ulpi_data_in = 8'h00;
    chk($sformatf("rsp_valid v%0d", idx), got, 1);
    ok = (log_q.size() == exp_q.size());
    for (int i = 0; i < exp_q.size() && ok; i++)
      if (log_q[i] !== exp_q[i]) ok = 0;
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL bus_seq v%0d: got %p expected %p", idx, log_q, exp_q);
    end
    chk($sformatf("stp_count v%0d", idx), stp_n, v.wr ? 1 : 0);
    chk($sformatf("rsp_error v%0d", idx), rsp_error, v.exp_err);
    if (!v.wr) begin
      chk($sformatf("rsp_rdata v%0d", idx), rsp_rdata, v.rdata);
      chk($sformatf("rsp_after_dir_fall v%0d", idx), rstep, 3);
      last_rd = v.rdata;
    end
  endtask

  initial begin
    bit got;
    bit seen;
    int n;
    int cmd_n;
    int stp_n;
    int aborts;
    int pulses;

    vecs[0] = '{wr:1, ext:0, addr:8'h0A, wdata:8'h00, nxt_wait:1,
                rdata:8'h00, exp_cmd:8'h8A, exp_err:0};
    vecs[1] = '{wr:0, ext:0, addr:8'h00, wdata:8'h00, nxt_wait:0,
                rdata:8'h24, exp_cmd:8'hC0, exp_err:0};
    vecs[2] = '{wr:1, ext:1, addr:8'h85, wdata:8'h5A, nxt_wait:0,
                rdata:8'h00, exp_cmd:8'hAF, exp_err:0};
    vecs[3] = '{wr:0, ext:1, addr:8'h2F, wdata:8'h00, nxt_wait:2,
                rdata:8'h3C, exp_cmd:8'hEF, exp_err:0};
    vecs[4] = '{wr:1, ext:0, addr:8'h3E, wdata:8'hFF, nxt_wait:0,
                rdata:8'h00, exp_cmd:8'hBE, exp_err:0};
    vecs[5] = '{wr:0, ext:0, addr:8'h15, wdata:8'h99, nxt_wait:3,
                rdata:8'hA5, exp_cmd:8'hD5, exp_err:0};
    vecs[6] = '{wr:0, ext:1, addr:8'hC1, wdata:8'h00, nxt_wait:0,
                rdata:8'h81, exp_cmd:8'hEF, exp_err:0};

    reset = 1'b1;
    req_valid = 1'b0;
    req_valid2 = 1'b0;
    req_write = 1'b0;
    req_addr = 8'h00;
    req_wdata = 8'h00;
    ulpi_dir = 1'b0;
    ulpi_nxt = 1'b0;
    ulpi_data_in = 8'h00;

    @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst data_out", ulpi_data_out, 8'h00);
    chk("rst oe", ulpi_data_oe, 0);
    chk("rst stp", ulpi_stp, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_error", rsp_error, 0);
    chk("rst rsp_rdata", rsp_rdata, 8'h00);
    chk("rst req_ready", req_ready, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Extended address with extended addressing disabled
    @(negedge clk);
    req_valid2 = 1'b1;
    req_write = 1'b1;
    req_addr = 8'h85;
    req_wdata = 8'h5A;
    #1;
    chk("noext req_ready", req_ready2, 1);
    got = 0;
    seen = 0;
    n = 0;
    for (int c = 1; c <= 2 && !got; c++) begin
      @(negedge clk);
      req_valid2 = 1'b0;
      if (oe2 || stp2) seen = 1;
      if (rsp_valid2) begin
        got = 1;
        n = c;
      end
    end
    chk("noext rsp_valid", got, 1);
    chk("noext rsp_error", rsp_error2, 1);
    chk("noext bus_quiet", seen, 0);
    chk("noext latency_le2", n >= 1 && n <= 2, 1);

    // DIR held 3 cycles during TXCMD, then retry succeeds
    issue(1, 8'h04, 8'h11);
    chk("abort first_cmd", ulpi_data_out, 8'h84);
    ulpi_dir = 1'b1;
    #1;
    chk("abort oe_same_cycle", ulpi_data_oe, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    ulpi_dir = 1'b0;
    @(negedge clk);
    chk("abort redrive_oe", ulpi_data_oe, 1);
    chk("abort redrive_cmd", ulpi_data_out, 8'h84);
    ulpi_nxt = 1'b1;
    got = 0;
    stp_n = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (ulpi_stp) stp_n++;
      if (rsp_valid) got = 1;
    end
    ulpi_nxt = 1'b0;
    chk("abort rsp_valid", got, 1);
    chk("abort rsp_error", rsp_error, 0);
    chk("abort stp_count", stp_n, 1);

    // Four consecutive aborts exhaust the retries
    issue(1, 8'h04, 8'h22);
    got = 0;
    aborts = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (rsp_valid) begin
        got = 1;
      end else begin
        if (ulpi_data_oe) begin
          ulpi_dir = 1'b1;
          aborts++;
        end else begin
          ulpi_dir = 1'b0;
        end
        @(negedge clk);
      end
    end
    ulpi_dir = 1'b0;
    chk("retry rsp_valid", got, 1);
    chk("retry rsp_error", rsp_error, 1);
    chk("retry abort_count", aborts, 4);

    // NXT never arrives
    issue(1, 8'h0A, 8'h33);
    got = 0;
    cmd_n = 0;
    stp_n = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      if (rsp_valid) begin
        got = 1;
      end else begin
        if (ulpi_stp) stp_n++;
        else if (ulpi_data_oe && ulpi_data_out == 8'h8A) cmd_n++;
        @(negedge clk);
      end
    end
    chk("timeout rsp_valid", got, 1);
    chk("timeout rsp_error", rsp_error, 1);
    chk("timeout txcmd_cycles", cmd_n, 16);
    chk("timeout stp_count", stp_n, 1);

    // Reset while waiting in RD_DATA behind an RXCMD
    issue(0, 8'h00, 8'h00);
    ulpi_nxt = 1'b1;
    @(negedge clk);
    ulpi_nxt = 1'b0;
    ulpi_dir = 1'b1;
    @(negedge clk);
    ulpi_nxt = 1'b1;
    ulpi_data_in = 8'h77;
    @(negedge clk);
    chk("rxcmd busy", busy, 1);
    chk("rxcmd no_capture", rsp_rdata, last_rd);
    pulses = 0;
    reset = 1'b1;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst oe", ulpi_data_oe, 0);
    chk("midrst stp", ulpi_stp, 0);
    chk("midrst data_out", ulpi_data_out, 8'h00);
    chk("midrst rsp_rdata", rsp_rdata, 8'h00);
    chk("midrst rsp_error", rsp_error, 0);
    ulpi_nxt = 1'b0;
    ulpi_dir = 1'b0;
    ulpi_data_in = 8'h00;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 1) reset = 1'b0;
      if (rsp_valid) pulses++;
    end
    chk("midrst no_rsp_pulse", pulses, 0);
    run_vec(7, vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
